// File: rtl/macro_iter_ctrl5_if.sv
// rtl/macro_iter_ctrl5_if.sv - request, step and response handshake bundle for macro_iter_ctrl5
interface macro_iter_ctrl5_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [4:0] req_cnt0;
    logic [4:0] req_cnt1;
    logic       abort;
    logic       step_valid;
    logic       step_ready;
    logic [4:0] step_idx;
    logic       step_last;
    logic       step_id;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_id;
    logic       resp_abort;

    modport slave (
        input  req_valid, req_cnt0, req_cnt1, abort, step_ready, resp_ready,
        output req_ready, step_valid, step_idx, step_last, step_id,
               resp_valid, resp_id, resp_abort
    );

    modport master (
        output req_valid, req_cnt0, req_cnt1, abort, step_ready, resp_ready,
        input  req_ready, step_valid, step_idx, step_last, step_id,
               resp_valid, resp_id, resp_abort
    );
endinterface

// File: rtl/macro_iter_ctrl5.sv
// rtl/macro_iter_ctrl5.sv - two-requester round-robin iteration sequencer; MACRO_ITER_CTRL5_STALL_CNT_EN adds stall_cnt
module macro_rom_decr5 (
    input  logic [4:0] d,
    output logic [4:0] q,
    output logic       c
);
    assign {c, q} = {1'b0, d} - 6'd1;
endmodule

module macro_iter_ctrl5 (
    input  logic               clk,
    input  logic               reset,
    macro_iter_ctrl5_if.slave  bus
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
    ,
    output logic [7:0]         stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

    state_e     state_q, state_d;
    logic [4:0] rem_q, rem_d;
    logic       owner_q, owner_d;
    logic       abt_q, abt_d;
    logic       rr_q, rr_d;
    logic [1:0] gnt;
    logic [4:0] rom_q;
    logic       rom_c;

`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
    logic [7:0] stall_q, stall_d;
    assign stall_cnt = stall_q;
`endif

    macro_rom_decr5 u_rom (
        .d (rem_q),
        .q (rom_q),
        .c (rom_c)
    );

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        owner_d        = owner_q;
        abt_d          = abt_q;
        rr_d           = rr_q;
        gnt            = 2'b00;
        bus.req_ready  = 2'b00;
        bus.step_valid = 1'b0;
        bus.step_idx   = 5'd0;
        bus.step_last  = 1'b0;
        bus.step_id    = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_id    = 1'b0;
        bus.resp_abort = 1'b0;
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
        stall_d        = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid == 2'b11) gnt = rr_q ? 2'b10 : 2'b01;
                else                        gnt = bus.req_valid;
                // keep outputs quiet while reset is held, even with requests pending
                bus.req_ready = gnt & {2{~reset}};
                if (gnt != 2'b00) begin
                    state_d = RUN;
                    rem_d   = gnt[1] ? bus.req_cnt1 : bus.req_cnt0;
                    owner_d = gnt[1];
                    abt_d   = 1'b0;
                    rr_d    = ~gnt[1];
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
                    stall_d = 8'd0;
`endif
                end
            end
            RUN: begin
                bus.step_valid = ~bus.abort;
                bus.step_idx   = rem_q;
                bus.step_last  = rom_c;
                bus.step_id    = owner_q;
                if (bus.abort) begin
                    state_d = RESP;
                    abt_d   = 1'b1;
                end else if (bus.step_ready) begin
                    // the borrow case always leaves RUN, so rem never wraps
                    if (rom_c) state_d = RESP;
                    else       rem_d   = rom_q;
                end
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
                if (!bus.abort && !bus.step_ready && stall_q != 8'hff)
                    stall_d = stall_q + 8'd1;
`endif
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_id    = owner_q;
                bus.resp_abort = abt_q;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= 5'd0;
            owner_q <= 1'b0;
            abt_q   <= 1'b0;
            rr_q    <= 1'b0;
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
            stall_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            abt_q   <= abt_d;
            rr_q    <= rr_d;
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
            stall_q <= stall_d;
`endif
        end
    end
endmodule

// File: tb/tb_macro_iter_ctrl5.sv
// tb/tb_macro_iter_ctrl5.sv - vector table, corner sequences and random model check for macro_iter_ctrl5
module tb_macro_iter_ctrl5;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    macro_iter_ctrl5_if bus();
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
    logic [7:0] stall_cnt;
`endif

    macro_iter_ctrl5 dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic [1:0] rv;
        logic [4:0] c0, c1;
        logic       ab, sr, pr;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nfail = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic addv(input logic r, input logic [1:0] rv, input logic [4:0] c0, input logic [4:0] c1,
                        input logic ab, input logic sr, input logic pr,
                        input logic [1:0] err, input logic esv, input logic [4:0] eidx, input logic elast,
                        input logic esid, input logic erv, input logic erid, input logic erab);
        vec_t v;
        v.rst = r; v.rv = rv; v.c0 = c0; v.c1 = c1; v.ab = ab; v.sr = sr; v.pr = pr;
        v.exp = {err, esv, eidx, elast, esid, erv, erid, erab};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] rv, input logic [4:0] c0, input logic [4:0] c1,
                         input logic ab, input logic sr, input logic pr);
        rst = r; bus.req_valid = rv; bus.req_cnt0 = c0; bus.req_cnt1 = c1;
        bus.abort = ab; bus.step_ready = sr; bus.resp_ready = pr;
    endtask

    function automatic logic [12:0] outs();
        return {bus.req_ready, bus.step_valid, bus.step_idx, bus.step_last, bus.step_id,
                bus.resp_valid, bus.resp_id, bus.resp_abort};
    endfunction

    // transaction-level reference: queue of step indices still owed, then a pending response
    int         m_q[$];
    bit         m_rp, m_owner, m_abt, m_prio;
    int         m_stall;
    int         w;
    logic [1:0] e_rr;
    logic       e_sv, e_last, e_sid, e_rv, e_rid, e_rab;
    logic [4:0] e_idx;
    logic       r_rst, r_ab, r_sr, r_pr;
    logic [1:0] r_rv;
    logic [4:0] r_c0, r_c1;

    initial begin
        drive(1, 2'b00, 0, 0, 0, 0, 0);

        addv(1, 2'b00, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b01, 3, 0, 0, 1, 1,  2'b01, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 3, 0, 0, 1, 1,  2'b00, 1, 3, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 3, 0, 0, 1, 1,  2'b00, 1, 2, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 3, 0, 0, 1, 1,  2'b00, 1, 1, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 3, 0, 0, 1, 1,  2'b00, 1, 0, 1, 0, 0, 0, 0);
        addv(0, 2'b00, 3, 0, 0, 1, 1,  2'b00, 0, 0, 0, 0, 1, 0, 0);
        addv(1, 2'b00, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b11, 0, 2, 0, 1, 1,  2'b01, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b11, 0, 2, 0, 1, 1,  2'b00, 1, 0, 1, 0, 0, 0, 0);
        addv(0, 2'b11, 0, 2, 0, 1, 1,  2'b00, 0, 0, 0, 0, 1, 0, 0);
        addv(0, 2'b11, 0, 2, 0, 1, 1,  2'b10, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 0, 2, 0, 1, 1,  2'b00, 1, 2, 0, 1, 0, 0, 0);
        addv(0, 2'b00, 0, 2, 0, 1, 1,  2'b00, 1, 1, 0, 1, 0, 0, 0);
        addv(0, 2'b00, 0, 2, 0, 1, 1,  2'b00, 1, 0, 1, 1, 0, 0, 0);
        addv(0, 2'b00, 0, 2, 0, 1, 1,  2'b00, 0, 0, 0, 0, 1, 1, 0);
        addv(0, 2'b11, 5, 2, 0, 1, 1,  2'b01, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 5, 2, 0, 1, 1,  2'b00, 1, 5, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 5, 2, 0, 1, 1,  2'b00, 1, 4, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 5, 2, 1, 1, 1,  2'b00, 0, 3, 0, 0, 0, 0, 0);
        addv(0, 2'b11, 5, 10, 0, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        addv(0, 2'b11, 5, 10, 1, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        addv(0, 2'b11, 5, 10, 0, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        addv(0, 2'b11, 5, 10, 0, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        addv(0, 2'b11, 5, 10, 0, 1, 1, 2'b00, 0, 0, 0, 0, 1, 0, 1);
        addv(0, 2'b11, 5, 10, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 0, 0, 0, 1, 1,  2'b00, 1, 10, 0, 1, 0, 0, 0);
        addv(0, 2'b00, 0, 0, 0, 1, 1,  2'b00, 1, 9, 0, 1, 0, 0, 0);
        addv(0, 2'b00, 0, 0, 0, 1, 1,  2'b00, 1, 8, 0, 1, 0, 0, 0);
        addv(0, 2'b00, 0, 0, 0, 1, 1,  2'b00, 1, 7, 0, 1, 0, 0, 0);
        addv(1, 2'b00, 0, 0, 0, 1, 1,  2'b00, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b00, 0, 0, 0, 1, 1,  2'b00, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 2'b11, 1, 4, 0, 1, 1,  2'b01, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].rv, tbl[i].c0, tbl[i].c1, tbl[i].ab, tbl[i].sr, tbl[i].pr);
            #1;
            chk($sformatf("vec%0d", i), {3'b0, outs()}, {3'b0, tbl[i].exp});
        end

        // N=31 on requester 1 with step_ready alternating 0/1
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 2'b10, 0, 31, 0, 0, 0);
        #1 chk("n31_grant", {14'b0, bus.req_ready}, 16'd2);
        begin
            int expi = 31, hs = 0, stalls = 0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                @(negedge clk);
                drive(0, 2'b00, 0, 31, 0, cyc[0], 0);
                #1;
                if (bus.resp_valid) break;
                chk("n31_valid", {15'b0, bus.step_valid}, 16'd1);
                chk("n31_idx", {11'b0, bus.step_idx}, expi[15:0]);
                chk("n31_last", {15'b0, bus.step_last}, {15'b0, expi == 0});
                chk("n31_id", {15'b0, bus.step_id}, 16'd1);
                if (bus.step_ready) begin hs++; expi--; end
                else stalls++;
            end
            chk("n31_resp", {15'b0, bus.resp_valid}, 16'd1);
            chk("n31_steps", hs[15:0], 16'd32);
            chk("n31_resp_id", {15'b0, bus.resp_id}, 16'd1);
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
            chk("n31_stall_cnt", {8'b0, stall_cnt}, stalls[15:0]);
`endif
        end
        @(negedge clk); drive(0, 2'b00, 0, 0, 0, 0, 1);

        // randomized run against the transaction model
        @(negedge clk); drive(1, 2'b00, 0, 0, 0, 0, 0);
        m_q.delete(); m_rp = 0; m_owner = 0; m_abt = 0; m_prio = 0; m_stall = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 199) == 0);
            r_rv  = 2'($urandom_range(0, 3));
            r_c0  = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r_c1  = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r_ab  = ($urandom_range(0, 15) == 0);
            r_sr  = ($urandom_range(0, 3) != 0);
            r_pr  = 1'($urandom_range(0, 1));
            drive(r_rst, r_rv, r_c0, r_c1, r_ab, r_sr, r_pr);
            #1;
            e_rr = 0; e_sv = 0; e_idx = 0; e_last = 0; e_sid = 0; e_rv = 0; e_rid = 0; e_rab = 0; w = -1;
            if (r_rst) begin
                m_q.delete(); m_rp = 0; m_owner = 0; m_abt = 0; m_prio = 0; m_stall = 0;
            end else if (m_q.size() > 0) begin
                e_sv = !r_ab; e_idx = 5'(m_q[0]); e_last = (m_q.size() == 1); e_sid = m_owner;
            end else if (m_rp) begin
                e_rv = 1; e_rid = m_owner; e_rab = m_abt;
            end else begin
                if (r_rv == 2'b11) w = m_prio ? 1 : 0;
                else if (r_rv == 2'b01) w = 0;
                else if (r_rv == 2'b10) w = 1;
                if (w >= 0) e_rr = (w == 1) ? 2'b10 : 2'b01;
            end
            chk($sformatf("rnd%0d", i), {3'b0, outs()},
                {3'b0, e_rr, e_sv, e_idx, e_last, e_sid, e_rv, e_rid, e_rab});
`ifdef MACRO_ITER_CTRL5_STALL_CNT_EN
            chk($sformatf("rnd_stall%0d", i), {8'b0, stall_cnt}, m_stall[15:0]);
`endif
            if (r_rst) begin
            end else if (m_q.size() > 0) begin
                if (r_ab) begin
                    m_q.delete(); m_rp = 1; m_abt = 1;
                end else if (r_sr) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_rp = 1;
                end else if (m_stall < 255) m_stall++;
            end else if (m_rp) begin
                if (r_pr) m_rp = 0;
            end else if (w >= 0) begin
                for (int k = (w == 1 ? int'(r_c1) : int'(r_c0)); k >= 0; k--) m_q.push_back(k);
                m_owner = (w == 1); m_abt = 0; m_prio = (w == 0); m_stall = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
